cipher_arbiter: RTL and testbench
=================================

Name: cipher_arbiter

Overview:
- Shares one `cipher` core between N_REQ independent requesters using round-robin arbitration.
- Captures a requester's plaintext and round count, then pulses the core's `en` and waits for `en_o`.
- Returns the ciphertext to the owning requester over a valid/ready result channel.
- Sits between the AXI/stream front-ends and `cipher`. Key fetch (key_req/key_valid) stays a direct connection and is not touched here.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- TIMEOUT_CYC, 64, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_plaintext  in  N_REQ*`BLK_S  packed plaintexts; requester i in slice i
- req_rounds  in  N_REQ*`Nb  packed rounds_total values
- res_valid  out  N_REQ  per-requester result valid; one-hot or zero
- res_ready  in  N_REQ  per-requester result accept
- res_data  out  `BLK_S  ciphertext, shared by all requesters
- res_err  out  1  qualified by res_valid; 1 = rejected or timed out
- cipher_en  out  1  single-cycle start pulse to cipher.en
- cipher_rounds_total  out  `Nb  driven to cipher.rounds_total
- cipher_plaintext  out  `BLK_S  driven to cipher.plaintext
- cipher_ciphertext  in  `BLK_S  from cipher.ciphertext
- cipher_en_o  in  1  from cipher.en_o (done)

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: req_ready, res_valid, cipher_en, res_err, res_data, cipher_plaintext, cipher_rounds_total all 0.
  - Internal: rr_ptr=0, owner=0, state=IDLE.
- State machine: IDLE -> GRANT -> LAUNCH -> BUSY -> RESP -> IDLE.
- IDLE:
  - Pick the first i with req_valid[i]=1, searching from rr_ptr and wrapping modulo N_REQ.
  - If none, stay in IDLE.
- GRANT (1 cycle):
  - Assert req_ready[owner]; the requester handshake completes this cycle.
  - Register the owner's plaintext and rounds onto cipher_plaintext / cipher_rounds_total.
  - Set rr_ptr = (owner+1) mod N_REQ.
  - If rounds is not 10, 12 or 14: go straight to RESP with res_err=1, res_data=0.
- LAUNCH (1 cycle): cipher_en=1. cipher_plaintext and cipher_rounds_total are held stable from GRANT until RESP exits.
- BUSY:
  - Wait for cipher_en_o=1.
  - On that cycle, capture cipher_ciphertext into res_data and set res_err=0.
- RESP:
  - res_valid[owner]=1, with res_data/res_err stable.
  - Exit to IDLE on res_ready[owner]=1.
  - res_ready on non-owner bits is ignored.
- Latency and throughput:
  - req_valid rising in IDLE to req_ready: 1 cycle.
  - req_ready to cipher_en: 1 cycle.
  - cipher_en_o to res_valid: 1 cycle.
  - One block is in flight at a time; no back-to-back overlap.
- Fairness: when all requesters are continuously valid, grants rotate 0,1,..,N_REQ-1,0. No requester waits more than N_REQ-1 other grants.
- Request rules:
  - A requester dropping req_valid before its grant loses nothing and is simply skipped.
  - A requester dropping req_valid after its grant is already committed and still receives its result.
- cipher_en_o outside BUSY is ignored.
- Simultaneous res_ready and a new req_valid in RESP: the new request is arbitrated in the following IDLE cycle. No bypass.
- Reset asserted mid-operation: all state returns to reset values at once and any in-flight result is discarded. The bench must also reset `cipher` to the same reset.

Optional Feature:
- Macro: CIPHER_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on LAUNCH and increments in BUSY.
  - On reaching TIMEOUT_CYC without cipher_en_o: go to RESP with res_err=1, res_data=0.
  - A late cipher_en_o from that timed-out operation is ignored.
- Undefined: BUSY waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package `aes_pkg`:
  - arb_state_t enum {IDLE, GRANT, LAUNCH, BUSY, RESP}.
  - Localparams NR_128=10, NR_192=12, NR_256=14, reusing `Nb/`BLK_S from aes.vh.
  - Function rounds_legal().
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs valid vector and rr_ptr; outputs grant index and any_valid. Reusable by a future key-slot arbiter.

Test Plan:
- Single request: req0 with plaintext 'h00112233445566778899aabbccddeeff, rounds 10, 128-bit key schedule -> res_valid[0] with res_data 'h69c4e0d86a7b0430d8cdb78070b4c55a, res_err=0; cipher_en high exactly 1 cycle.
- Contention: req0 (rounds 10) and req1 (rounds 14, 256-bit schedule) both valid from cycle 0 -> req0 granted first, then req1. res_data 'h69c4...c55a to requester 0, then 'h8ea2b7ca516745bfeafc49904b496089 to requester 1.
- Fairness: both valid continuously for 6 operations -> grant order 0,1,0,1,0,1.
- Illegal rounds: req1 rounds=7 -> req_ready[1], then res_valid[1] with res_err=1 and res_data=0; cipher_en never asserted.
- Backpressure and reset: hold res_ready=0 for 20 cycles -> res_valid and res_data stable. Then drive reset=0 mid-BUSY on a second operation -> all outputs 0 within the same cycle, and the arbiter accepts a fresh request after release.
- With CIPHER_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tie cipher_en_o=0 -> res_err=1 exactly 16 cycles after LAUNCH plus 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-side types and constants for the cipher front-end logic.
// Holds the arbiter state encoding, block/round widths and the legal round
// counts of the three AES key sizes.
package aes_pkg;

  // Width of a rounds_total value and of one cipher block.
  localparam int unsigned NB    = 4;
  localparam int unsigned BLK_S = 128;

  // Round counts for 128/192/256-bit keys.
  localparam logic [NB-1:0] NR_128 = 4'd10;
  localparam logic [NB-1:0] NR_192 = 4'd12;
  localparam logic [NB-1:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    BUSY,
    RESP
  } arb_state_t;

  // True when the requested round count matches a real AES key size.
  function automatic logic rounds_legal(input logic [NB-1:0] rounds);
    return (rounds == NR_128) || (rounds == NR_192) || (rounds == NR_256);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted valid bit
// at or after ptr_i, wrapping around the vector. Kept generic so a future
// key-slot arbiter can reuse it.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_valid_o
);

  // Two descending passes with last-write-wins: the wrapped region (below
  // ptr) is the fallback, the region at/after ptr overrides it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    grant_o     = '0;
    any_valid_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_i[i] && (IDX_W'(i) < ptr_i)) begin
        grant_o     = IDX_W'(i);
        any_valid_o = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_i[i] && (IDX_W'(i) >= ptr_i)) begin
        grant_o     = IDX_W'(i);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cipher_arbiter.sv
// Round-robin arbiter sharing one cipher core between N_REQ requesters
// (legal N_REQ range 2..4). One block is in flight at a time:
// IDLE -> GRANT -> LAUNCH -> BUSY -> RESP -> IDLE.
// Optional BUSY watchdog: define CIPHER_ARB_TIMEOUT_EN (adds TIMEOUT_CYC).
module cipher_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned N_REQ = 2
`ifdef CIPHER_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*BLK_S-1:0] req_plaintext,
  input  logic [N_REQ*NB-1:0]    req_rounds,
  output logic [N_REQ-1:0]       res_valid,
  input  logic [N_REQ-1:0]       res_ready,
  output logic [BLK_S-1:0]       res_data,
  output logic                   res_err,
  output logic                   cipher_en,
  output logic [NB-1:0]          cipher_rounds_total,
  output logic [BLK_S-1:0]       cipher_plaintext,
  input  logic [BLK_S-1:0]       cipher_ciphertext,
  input  logic                   cipher_en_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state_q;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic [N_REQ-1:0] req_ready_q;
  logic [N_REQ-1:0] res_valid_q;
  logic [BLK_S-1:0] res_data_q;
  logic             res_err_q;
  logic             cipher_en_q;
  logic [BLK_S-1:0] cipher_pt_q;
  logic [NB-1:0]    cipher_rounds_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [BLK_S-1:0] sel_pt;
  logic [NB-1:0]    sel_rounds;
  logic             res_ack;

`ifdef CIPHER_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid_i     (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (pick_idx),
    .any_valid_o (pick_any)
  );

  // Owner's request slice and the next round-robin pointer.
  always_comb begin
    sel_pt     = '0;
    sel_rounds = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        sel_pt     = req_plaintext[i*BLK_S +: BLK_S];
        sel_rounds = req_rounds[i*NB +: NB];
      end
    end
    rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  // res_valid is one-hot on the owner in RESP, so this masks off non-owner readies.
  assign res_ack = |(res_ready & res_valid_q);

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      req_ready_q     <= '0;
      res_valid_q     <= '0;
      res_data_q      <= '0;
      res_err_q       <= 1'b0;
      cipher_en_q     <= 1'b0;
      cipher_pt_q     <= '0;
      cipher_rounds_q <= '0;
`ifdef CIPHER_ARB_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every branch reads pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q     <= pick_idx;
            req_ready_q <= onehot(pick_idx);
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          req_ready_q     <= '0;
          cipher_pt_q     <= sel_pt;
          cipher_rounds_q <= sel_rounds;
          rr_ptr_q        <= rr_ptr_d;
          if (rounds_legal(sel_rounds)) begin
            cipher_en_q <= 1'b1;
            state_q     <= LAUNCH;
          end else begin
            res_valid_q <= onehot(owner_q);
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            state_q     <= RESP;
          end
        end
        LAUNCH: begin
          cipher_en_q <= 1'b0;
          state_q     <= BUSY;
`ifdef CIPHER_ARB_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        BUSY: begin
          if (cipher_en_o) begin
            res_data_q  <= cipher_ciphertext;
            res_err_q   <= 1'b0;
            res_valid_q <= onehot(owner_q);
            state_q     <= RESP;
          end
`ifdef CIPHER_ARB_TIMEOUT_EN
          // Last BUSY cycle of the window: report a timeout instead of waiting.
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= onehot(owner_q);
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          if (res_ack) begin
            res_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready           = req_ready_q;
  assign res_valid           = res_valid_q;
  assign res_data            = res_data_q;
  assign res_err             = res_err_q;
  assign cipher_en           = cipher_en_q;
  assign cipher_plaintext    = cipher_pt_q;
  assign cipher_rounds_total = cipher_rounds_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
// Self-checking bench for cipher_arbiter with a behavioural cipher stand-in
// and a scoreboard of expected results. Define CIPHER_ARB_TIMEOUT_EN to
// also exercise the watchdog with TIMEOUT_CYC=16.
module tb_cipher_arbiter;
  import aes_pkg::*;

  localparam int N         = 2;
  localparam int MODEL_LAT = 12;
  localparam logic [127:0] PT0    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [N-1:0] owner;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N*BLK_S-1:0] req_plaintext = '0;
  logic [N*NB-1:0]    req_rounds = '0;
  logic [N-1:0]       res_valid;
  logic [N-1:0]       res_ready = '0;
  logic [BLK_S-1:0]   res_data;
  logic               res_err;
  logic               cipher_en;
  logic [NB-1:0]      cipher_rounds_total;
  logic [BLK_S-1:0]   cipher_plaintext;
  logic [BLK_S-1:0]   cipher_ciphertext = '1;
  logic               cipher_en_o = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Cipher stand-in state.
  logic         model_en = 1'b1;
  int           model_cnt = 0;
  logic [127:0] model_ct = '0;
  int           en_o_cyc = 0;

  // cipher_en monitor state.
  int en_pulses = 0;
  int en_run = 0;
  int en_max_run = 0;
  int en_rise_cyc = 0;

  cipher_arbiter #(
    .N_REQ (N)
`ifdef CIPHER_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_plaintext       (req_plaintext),
    .req_rounds          (req_rounds),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data),
    .res_err             (res_err),
    .cipher_en           (cipher_en),
    .cipher_rounds_total (cipher_rounds_total),
    .cipher_plaintext    (cipher_plaintext),
    .cipher_ciphertext   (cipher_ciphertext),
    .cipher_en_o         (cipher_en_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] ref_cipher(input logic [127:0] pt, input logic [3:0] r);
    if (pt == PT0 && r == 4'd10) return CT128;
    if (pt == PT0 && r == 4'd14) return CT256;
    return pt ^ {8{16'h5a5a}};
  endfunction

  // Cipher stand-in: answers MODEL_LAT cycles after cipher_en, shares the arbiter reset.
  always @(negedge clk) begin
    if (!reset) begin
      model_cnt         = 0;
      cipher_en_o       = 1'b0;
      cipher_ciphertext = '1;
    end else begin
      cipher_en_o       = 1'b0;
      cipher_ciphertext = '1;
      if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          cipher_en_o       = 1'b1;
          cipher_ciphertext = model_ct;
          en_o_cyc          = cyc;
        end
      end
      if (cipher_en && model_en) begin
        model_cnt = MODEL_LAT;
        model_ct  = ref_cipher(cipher_plaintext, cipher_rounds_total);
      end
    end
  end

  // Tracks cipher_en pulse count, longest high run and the rise cycle.
  always @(negedge clk) begin
    if (cipher_en) begin
      en_run = en_run + 1;
      if (en_run == 1) begin
        en_pulses   = en_pulses + 1;
        en_rise_cyc = cyc;
      end
      if (en_run > en_max_run) en_max_run = en_run;
    end else begin
      en_run = 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [127:0] pt, input logic [3:0] r);
    req_plaintext[i*BLK_S +: BLK_S] = pt;
    req_rounds[i*NB +: NB]          = r;
    req_valid[i]                    = 1'b1;
  endtask

  task automatic expect_res(input int i, input logic [127:0] data, input logic err);
    exp_t e;
    e.owner = N'(1) << i;
    e.data  = data;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int i, input string tag, output int g_cyc);
    int n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    g_cyc = cyc;
    check(tag, 128'(req_ready), 128'(N'(1) << i));
  endtask

  task automatic wait_en(input string tag, input int base);
    int n = 0;
    while (en_pulses == base && n < 10) begin
      tick();
      n++;
    end
    check(tag, 128'(en_pulses), 128'(base + 1));
  endtask

  task automatic wait_result(input string tag, output int r_cyc);
    int   n = 0;
    exp_t e;
    while (res_valid == '0 && n < 100) begin
      tick();
      n++;
    end
    r_cyc = cyc;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 128'(res_valid), 128'(e.owner));
      check({tag, "_data"}, res_data, e.data);
      check({tag, "_err"}, 128'(res_err), 128'(e.err));
    end
  endtask

  task automatic ack(input int i, input string tag);
    res_ready = N'(1) << i;
    tick();
    res_ready = '0;
    check({tag, "_released"}, 128'(res_valid), 128'(0));
  endtask

  initial begin
    int g_cyc;
    int r_cyc;
    int d_cyc;
    int en_base;
    logic         stable;
    logic [127:0] snap_data;

    // Reset state.
    tick();
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_misc", 128'({cipher_en, res_err, cipher_rounds_total}), 128'(0));
    check("rst_res_data", res_data, 128'(0));
    check("rst_cipher_pt", cipher_plaintext, 128'(0));
    reset = 1'b1;
    tick();

    // Contention right after reset: requester 0 wins first.
    drive_req(0, PT0, 4'd10);
    drive_req(1, PT0, 4'd14);
    expect_res(0, CT128, 1'b0);
    expect_res(1, CT256, 1'b0);
    wait_grant(0, "cont_grant0", g_cyc);
    req_valid[0] = 1'b0;
    wait_result("cont_res0", r_cyc);
    ack(0, "cont_res0");
    wait_grant(1, "cont_grant1", g_cyc);
    req_valid[1] = 1'b0;
    wait_result("cont_res1", r_cyc);
    ack(1, "cont_res1");

    // Single request with latency checks.
    en_base = en_pulses;
    tick();
    d_cyc = cyc;
    drive_req(0, PT0, 4'd10);
    expect_res(0, CT128, 1'b0);
    wait_grant(0, "single_grant", g_cyc);
    req_valid[0] = 1'b0;
    check("lat_req_to_ready", 128'(g_cyc - d_cyc), 128'(1));
    wait_en("single_en", en_base);
    check("lat_ready_to_en", 128'(en_rise_cyc - g_cyc), 128'(1));
    wait_result("single_res", r_cyc);
    check("lat_en_o_to_valid", 128'(r_cyc - en_o_cyc), 128'(1));
    check("en_one_cycle", 128'(en_max_run), 128'(1));
    ack(0, "single_res");

    // Illegal rounds: error result and no cipher launch.
    en_base = en_pulses;
    drive_req(1, PT0, 4'd7);
    expect_res(1, 128'(0), 1'b1);
    wait_grant(1, "illegal_grant", g_cyc);
    req_valid[1] = 1'b0;
    wait_result("illegal_res", r_cyc);
    ack(1, "illegal_res");
    check("illegal_no_en", 128'(en_pulses), 128'(en_base));

    // Fairness: both continuously valid for six operations.
    drive_req(0, PT0, 4'd10);
    drive_req(1, PT0, 4'd10);
    for (int op = 0; op < 6; op++) begin
      expect_res(op % 2, CT128, 1'b0);
      wait_grant(op % 2, $sformatf("fair_grant%0d", op), g_cyc);
      if (op == 5) req_valid = '0;
      wait_result($sformatf("fair_res%0d", op), r_cyc);
      ack(op % 2, $sformatf("fair_res%0d", op));
    end

    // Backpressure: result held stable for 20 cycles.
    drive_req(0, PT0, 4'd14);
    expect_res(0, CT256, 1'b0);
    wait_grant(0, "bp_grant", g_cyc);
    req_valid[0] = 1'b0;
    wait_result("bp_res", r_cyc);
    snap_data = res_data;
    stable    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid !== 2'b01 || res_data !== snap_data) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'(1));
    ack(0, "bp_res");

    // Reset mid-BUSY: in-flight result discarded, outputs clear immediately.
    en_base = en_pulses;
    drive_req(0, PT0, 4'd12);
    wait_grant(0, "rst_op_grant", g_cyc);
    req_valid[0] = 1'b0;
    wait_en("rst_op_en", en_base);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_handshake", 128'({req_ready, res_valid, cipher_en, res_err}), 128'(0));
    check("midrst_res_data", res_data, 128'(0));
    check("midrst_cipher", 128'({cipher_plaintext, cipher_rounds_total}), 128'(0));
    tick();
    tick();
    reset = 1'b1;

    // Fresh requests after reset: pointer restarts at requester 0.
    drive_req(0, PT0, 4'd10);
    drive_req(1, PT0, 4'd14);
    expect_res(0, CT128, 1'b0);
    expect_res(1, CT256, 1'b0);
    wait_grant(0, "post_rst_grant0", g_cyc);
    req_valid[0] = 1'b0;
    wait_result("post_rst_res0", r_cyc);
    ack(0, "post_rst_res0");
    wait_grant(1, "post_rst_grant1", g_cyc);
    req_valid[1] = 1'b0;
    wait_result("post_rst_res1", r_cyc);
    ack(1, "post_rst_res1");

`ifdef CIPHER_ARB_TIMEOUT_EN
    // Watchdog: the core never answers.
    model_en = 1'b0;
    en_base  = en_pulses;
    drive_req(0, PT0, 4'd10);
    expect_res(0, 128'(0), 1'b1);
    wait_grant(0, "tmo_grant", g_cyc);
    req_valid[0] = 1'b0;
    wait_en("tmo_en", en_base);
    wait_result("tmo_res", r_cyc);
    check("tmo_latency", 128'(r_cyc - en_rise_cyc), 128'(17));
    ack(0, "tmo_res");
    model_en = 1'b1;
`endif

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case a wait loop is bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
